// File: rtl/attempt_ctrl_if.sv
// User-side and counter-side signals of the password-lock attempt controller.
// The controller takes the slave modport; the driving side (bench or datapath) takes master.
interface attempt_ctrl_if;
    logic       start;
    logic       enter;
    logic [3:0] code;
    logic [3:0] count;
    logic       load;
    logic       decrement;
    logic       unlocked;
    logic       blocked;
    logic       busy;

    modport master (
        output start, enter, code, count,
        input  load, decrement, unlocked, blocked, busy
    );

    modport slave (
        input  start, enter, code, count,
        output load, decrement, unlocked, blocked, busy
    );
endinterface

// File: rtl/attempt_ctrl.sv
// Password-lock controller: reloads and decrements an external attempt counter,
// unlocks on the secret code and blocks once the counter reports zero attempts left.
module attempt_ctrl #(
    parameter logic [3:0] SECRET        = 4'b1010,
    parameter int         UNLOCK_CYCLES = 8,
    parameter int         SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    attempt_ctrl_if.slave  bus
);

    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CYCLES - 1);
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        DEC,
        SETTLE,
        OPEN,
        BLOCKED
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] unlock_timer_reg;
    logic [1:0] settle_timer_reg;
    logic       load_reg;
    logic       decrement_reg;
    logic       unlocked_reg;
    logic       blocked_reg;
    logic       busy_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = LOAD;
            end
            LOAD: begin
                state_next = ARMED;
            end
            ARMED: begin
                // start wins over a same-cycle enter; the empty check guards an unloaded counter
                if (bus.start)                state_next = LOAD;
                else if (bus.enter)           state_next = (bus.code == SECRET) ? OPEN : DEC;
                else if (bus.count == 4'd0)   state_next = BLOCKED;
            end
            DEC: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_timer_reg == SETTLE_LAST)
                    state_next = (bus.count == 4'd0) ? BLOCKED : ARMED;
            end
            OPEN: begin
                if (bus.start)                           state_next = LOAD;
                else if (unlock_timer_reg == UNLOCK_LAST) state_next = IDLE;
            end
            BLOCKED: begin
                if (bus.start) state_next = LOAD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they always equal a decode of state_reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            unlock_timer_reg <= '0;
            settle_timer_reg <= '0;
            load_reg         <= 1'b0;
            decrement_reg    <= 1'b0;
            unlocked_reg     <= 1'b0;
            blocked_reg      <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            unlock_timer_reg <= (state_reg == OPEN && state_next == OPEN)
                                ? unlock_timer_reg + 8'd1 : '0;
            settle_timer_reg <= (state_reg == SETTLE && state_next == SETTLE)
                                ? settle_timer_reg + 2'd1 : '0;
            load_reg         <= (state_next == LOAD);
            decrement_reg    <= (state_next == DEC);
            unlocked_reg     <= (state_next == OPEN);
            blocked_reg      <= (state_next == BLOCKED);
            busy_reg         <= (state_next == LOAD) || (state_next == DEC) || (state_next == SETTLE);
        end
    end

    assign bus.load      = load_reg;
    assign bus.decrement = decrement_reg;
    assign bus.unlocked  = unlocked_reg;
    assign bus.blocked   = blocked_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: doc/attempt_ctrl.md
Name: attempt_ctrl

Overview:
- Password-lock controller that drives the attempt counter from the other side of its load/decrement/count interface.
- Asserts `load` to reload the attempt budget and `decrement` on every wrong code, and reads the counter's 4-bit count back to decide when to block.
- Sits between the user inputs (code switches plus enter button) and the attempt counter in the lock datapath.

Parameters:
- SECRET, 4'b1010, code that unlocks.
- UNLOCK_CYCLES, 8, number of cycles `unlocked` stays high before auto-relock (1..255).
- SETTLE_CYCLES, 1, wait cycles after a decrement pulse before sampling `count` (1..3).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  arm / re-arm request; level sampled each cycle.
- enter  input  1  code-submit strobe; one-cycle pulse, sampled only in ARMED.
- code  input  4  code under test, valid when enter=1.
- count  input  4  attempts remaining, from counter output.
- load  output  1  one-cycle request to counter to reload its budget.
- decrement  output  1  one-cycle request to counter to subtract one.
- unlocked  output  1  high while state=OPEN.
- blocked  output  1  high while state=BLOCKED.
- busy  output  1  high in LOAD, DEC and SETTLE; user inputs ignored.

Behaviour:
- All outputs are registered (Moore) and decoded from the state.
- Reset:
  - rst=0 forces state IDLE immediately, independent of clk.
  - load, decrement, unlocked, blocked and busy all go to 0.
  - Unlock timer and settle timer clear to 0.
- States: IDLE, LOAD, ARMED, DEC, SETTLE, OPEN, BLOCKED.
- IDLE: all outputs 0. start=1 -> LOAD.
- LOAD:
  - load=1 and busy=1 for exactly one cycle, then -> ARMED unconditionally.
  - The counter reloads on the edge leaving LOAD, so count is valid in the first ARMED cycle.
- ARMED: priority is start, then enter, then empty check.
  - start=1 -> LOAD (reload budget). start beats a simultaneous enter; that enter is dropped.
  - enter=1 and code==SECRET -> OPEN.
  - enter=1 and code!=SECRET -> DEC.
  - count==0 with no enter -> BLOCKED (protects against an empty or unloaded counter).
- DEC: decrement=1 and busy=1 for exactly one cycle, then -> SETTLE.
- SETTLE:
  - busy=1 for SETTLE_CYCLES cycles, then sample count.
  - count==0 -> BLOCKED; else -> ARMED.
  - enter and start are ignored during LOAD, DEC and SETTLE (not queued).
- OPEN:
  - unlocked=1; timer counts 0..UNLOCK_CYCLES-1.
  - At terminal value -> IDLE (count is not reloaded; the next start reloads it).
  - start=1 in OPEN -> LOAD early.
  - enter in OPEN is ignored.
- BLOCKED:
  - blocked=1; stays indefinitely, and enter is ignored.
  - Only start=1 -> LOAD leaves it.
- Exclusivity: load and decrement are never high in the same cycle, and each is never high two consecutive cycles.
- Widths:
  - code/SECRET compare is a full 4-bit equality.
  - count compares to 4'd0 only. Values above the budget are legal and just mean more attempts.
  - Unlock timer width is 8 bits, with no wrap inside OPEN.
- Reset mid-operation (e.g. during DEC): decrement drops to 0 asynchronously. No further pulse is issued after release; the FSM restarts at IDLE.

Test Plan:
- Reset and arm: rst=0 for 2 cycles with start=1 -> all outputs 0. Release, start=1 -> load=1 for 1 cycle, then ARMED with count=4 from the counter model.
- Correct code: in ARMED, enter pulse with code=4'b1010 -> unlocked=1 for exactly 8 cycles, then IDLE. decrement is never asserted and count stays 4.
- Wrong codes: 4 wrong entries (code=4'b0000), each separated by 3 idle cycles. Each entry produces one decrement pulse and count goes 4->3->2->1->0. blocked=1 one SETTLE later; a further correct enter leaves blocked=1.
- Recovery: from BLOCKED, start=1 -> load pulse, count=4, ARMED. A correct code then unlocks.
- Simultaneous and ignored events:
  - start=1 and enter=1 (correct code) in the same ARMED cycle -> LOAD taken, no unlock.
  - enter asserted during busy=1 -> no extra decrement.
- Async reset mid-operation: assert rst=0 between clock edges while decrement=1 -> decrement falls before the next edge and the counter sees no second pulse. After release the state is IDLE.
